// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV64 pipeline
//
// Each cycle this block produces the PC and pipeline-register enables and
// flushes. The inputs it acts on are load-use hazards, EX redirects and the
// imem/dmem ready handshakes. When a redirect arrives while a fetch is still
// outstanding, the block tracks that fetch so the stale instruction never
// reaches ID.
//
// Optional feature macro: PIPE_CTRL_PERF_EN builds the performance counters.
// When it is undefined, stall_cycles and flush_count are tied to 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mem_read_EX, rd_EX        load in EX and its destination register
//   rs1_ID, rs2_ID            ID source registers
//   use_rs1_ID, use_rs2_ID    ID instruction reads rs1 / rs2
//   redirect_EX               EX resolved a taken branch/jump/trap
//   imem_req, imem_ready      fetch handshake
//   dmem_req, dmem_ready      MEM-stage data handshake
//   pc_en                     PC load enable
//   *_en                      pipeline register enables
//   *_flush                   bubble insert, only ever with matching *_en=1
//   draining                  stale fetch being discarded (IDRAIN)
//   stall_cycles, flush_count performance counters
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_EX,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             redirect_EX,
  input  logic             imem_req,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             draining,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    IDRAIN = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic dstall;
  logic istall;
  logic lu;
  logic redir_take;

  always_comb begin
    dstall = dmem_req & ~dmem_ready;
    istall = imem_req & ~imem_ready;
    // x0 is never a real dependency, so a load targeting it cannot hazard.
    lu     = mem_read_EX & (rd_EX != 5'd0) &
             ((use_rs1_ID & (rs1_ID == rd_EX)) |
              (use_rs2_ID & (rs2_ID == rd_EX)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    draining     = 1'b0;
    redir_take   = 1'b0;
    state_d      = state_q;

    if (!rst) begin
      if (dstall) begin
        // EX and earlier freeze. A pending redirect is presented again next cycle.
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (redirect_EX) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        redir_take  = 1'b1;
      end else if (lu) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else if (istall) begin
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end

      if (state_q == IDRAIN) begin
        // The returning fetch belongs to the old path. Hold the PC and bubble
        // IF/ID until that fetch lands, including the cycle it lands in.
        pc_en    = 1'b0;
        draining = 1'b1;
        if (if_id_en) begin
          if_id_flush = 1'b1;
        end
        if (imem_ready) begin
          state_d = RUN;
        end
      end else if (redir_take && istall) begin
        state_d = IDRAIN;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_en) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
      if (redir_take) begin
        flush_count_q <= flush_count_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read_EX;
  logic [4:0]       rd_EX;
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic             redirect_EX;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             draining;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_EX  (mem_read_EX),
    .rd_EX        (rd_EX),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .use_rs1_ID   (use_rs1_ID),
    .use_rs2_ID   (use_rs2_ID),
    .redirect_EX  (redirect_EX),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .draining     (draining),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex/mem_wb flushes, draining}
  logic [8:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_flush, draining};

  localparam logic [8:0] C_ZERO  = 9'b00000_000_0;
  localparam logic [8:0] C_RUN   = 9'b11111_000_0;
  localparam logic [8:0] C_LU    = 9'b00111_010_0;
  localparam logic [8:0] C_REDIR = 9'b11111_110_0;
  localparam logic [8:0] C_DST   = 9'b00001_001_0;
  localparam logic [8:0] C_DRAIN = 9'b01111_100_1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic u1, input logic u2,
                     input logic rdr, input logic ireq, input logic irdy,
                     input logic dreq, input logic drdy);
    mem_read_EX = mr;
    rd_EX       = rd;
    rs1_ID      = r1;
    rs2_ID      = r2;
    use_rs1_ID  = u1;
    use_rs2_ID  = u2;
    redirect_EX = rdr;
    imem_req    = ireq;
    imem_ready  = irdy;
    dmem_req    = dreq;
    dmem_ready  = drdy;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pexp(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("reset_ctl", 64'(ctl), 64'(C_ZERO));
    chk("reset_stall_cnt", 64'(stall_cycles), 64'd0);
    chk("reset_flush_cnt", 64'(flush_count), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("idle_run", 64'(ctl), 64'(C_RUN));
    step();

    // Load-use on rs1 for one cycle, then the load has moved on.
    drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_rs1", 64'(ctl), 64'(C_LU));
    step();
    idle();
    #1 chk("lu_released", 64'(ctl), 64'(C_RUN));
    step();
    // Destination x0 never hazards.
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_x0", 64'(ctl), 64'(C_RUN));
    step();
    // rs2 matches but is not used, so there is no hazard.
    drv(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_rs2_unused", 64'(ctl), 64'(C_RUN));
    step();
    // rs2 used and matching.
    drv(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_rs2", 64'(ctl), 64'(C_LU));
    step();

    // Plain fetch stall.
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("istall", 64'(ctl), 64'(9'b01111_100_0));
    step();

    // Redirect with no outstanding fetch.
    chk("flush_cnt_before", 64'(flush_count), pexp(0));
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("redir_nofetch", 64'(ctl), 64'(C_REDIR));
    step();
    idle();
    #1 chk("redir_stays_run", 64'(ctl), 64'(C_RUN));
    chk("flush_cnt_after", 64'(flush_count), pexp(1));
    chk("stall_cnt_a", 64'(stall_cycles), pexp(3));
    step();

    // Redirect during a fetch wait: three waiting cycles, then the exit cycle.
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("redir_fetchwait", 64'(ctl), 64'(C_REDIR));
    step();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk($sformatf("drain_wait%0d", i), 64'(ctl), 64'(C_DRAIN));
      step();
    end
    idle();
    #1 chk("drain_exit", 64'(ctl), 64'(C_DRAIN));
    step();
    #1 chk("first_fetch_clean", 64'(ctl), 64'(C_RUN));
    chk("stall_cnt_b", 64'(stall_cycles), pexp(7));
    chk("flush_cnt_b", 64'(flush_count), pexp(2));
    step();

    // Reset while draining.
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("pre_rst_drain", 64'(ctl), 64'(C_DRAIN));
    #1 rst = 1'b1;
    #1 chk("rst_mid_drain_ctl", 64'(ctl), 64'(C_ZERO));
    chk("rst_mid_drain_stall", 64'(stall_cycles), 64'd0);
    chk("rst_mid_drain_flush", 64'(flush_count), 64'd0);
    step();
    rst = 1'b0;
    idle();
    #1 chk("post_rst_run", 64'(ctl), 64'(C_RUN));
    chk("post_rst_cnt", 64'(stall_cycles), 64'd0);
    step();

    // Data stall for four cycles while a redirect is pending.
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #1 chk($sformatf("dstall%0d", i), 64'(ctl), 64'(C_DST));
      step();
    end
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("dstall_redir_taken", 64'(ctl), 64'(C_REDIR));
    step();
    idle();
    #1 chk("dstall_done", 64'(ctl), 64'(C_RUN));
    chk("dstall_stall_cnt", 64'(stall_cycles), pexp(4));
    chk("dstall_flush_cnt", 64'(flush_count), pexp(1));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
